board_b_bus_initiator: RTL and testbench

BOARD_B_BUS_INITIATOR -- requirements
Module: board_b_bus_initiator

---
 rtl/board_b_bus_initiator_if.sv | 37 +++
 rtl/board_b_bus_initiator.sv | 114 +++++++++++
 tb/tb_board_b_bus_initiator.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/board_b_bus_initiator_if.sv
// CPU request/response and board bus signals of the board B bus initiator.
// The master modport is the initiator's view. The slave modport is the CPU/board side.
interface board_b_bus_initiator_if;
    logic        cpu_req;
    logic        cpu_we;
    logic        cpu_io;
    logic [19:0] cpu_addr;
    logic [1:0]  cpu_be;
    logic [15:0] cpu_wdata;
    logic        cpu_busy;
    logic        cpu_ready;
    logic [15:0] cpu_rdata;
    logic        cpu_overrun;
    logic [19:0] A;
    logic [15:0] DIN;
    logic [1:0]  BYTE_SEL;
    logic        MRD;
    logic        MWR;
    logic        IORD;
    logic        IOWR;
    logic        CHARA;
    logic        CHARA_P;
    logic [15:0] BUS_DIN;
    logic        BUS_DIN_VALID;

    modport master (
        input  cpu_req, cpu_we, cpu_io, cpu_addr, cpu_be, cpu_wdata, BUS_DIN, BUS_DIN_VALID,
        output cpu_busy, cpu_ready, cpu_rdata, cpu_overrun,
               A, DIN, BYTE_SEL, MRD, MWR, IORD, IOWR, CHARA, CHARA_P
    );

    modport slave (
        output cpu_req, cpu_we, cpu_io, cpu_addr, cpu_be, cpu_wdata, BUS_DIN, BUS_DIN_VALID,
        input  cpu_busy, cpu_ready, cpu_rdata, cpu_overrun,
               A, DIN, BYTE_SEL, MRD, MWR, IORD, IOWR, CHARA, CHARA_P
    );
endinterface

// File: rtl/board_b_bus_initiator.sv
// Turns single-cycle CPU requests into SETUP/STROBE/HOLD board cycles; write latency STROBE_CYCLES+2.
// No backpressure: requests arriving while busy are dropped and flagged in sticky cpu_overrun.
module board_b_bus_initiator #(
    parameter int STROBE_CYCLES = 2,
    parameter int MAX_WAIT      = 6
) (
    input  logic                    CLK_32M,
    input  logic                    reset,
    board_b_bus_initiator_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [5:0] LEN_MIN = 6'(STROBE_CYCLES);
    localparam logic [5:0] LEN_MAX = 6'(STROBE_CYCLES + MAX_WAIT);

    state_t      state;
    logic        lat_we;
    logic        lat_io;
    logic [4:0]  cnt;
    logic [15:0] cap_dat;
    logic        cap_vld;

    logic [5:0]  cnt_inc;
    logic        have_dat;
    logic        strobe_done;

    // cnt_inc is the number of strobe cycles completed at the end of the current one
    assign cnt_inc     = {1'b0, cnt} + 6'd1;
    assign have_dat    = cap_vld | bus.BUS_DIN_VALID;
    assign strobe_done = lat_we ? (cnt_inc >= LEN_MIN)
                                : (((cnt_inc >= LEN_MIN) && have_dat) || (cnt_inc >= LEN_MAX));

    always_ff @(posedge CLK_32M) begin
        if (reset) begin
            state           <= IDLE;
            lat_we          <= 1'b0;
            lat_io          <= 1'b0;
            cnt             <= 5'd0;
            cap_dat         <= 16'h0000;
            cap_vld         <= 1'b0;
            bus.cpu_busy    <= 1'b0;
            bus.cpu_ready   <= 1'b0;
            bus.cpu_rdata   <= 16'hFFFF;
            bus.cpu_overrun <= 1'b0;
            bus.A           <= 20'h00000;
            bus.DIN         <= 16'h0000;
            bus.BYTE_SEL    <= 2'b00;
            bus.MRD         <= 1'b0;
            bus.MWR         <= 1'b0;
            bus.IORD        <= 1'b0;
            bus.IOWR        <= 1'b0;
            bus.CHARA       <= 1'b0;
            bus.CHARA_P     <= 1'b0;
        end else begin
            bus.cpu_ready <= 1'b0;
            if (bus.cpu_req && (state != IDLE)) begin
                bus.cpu_overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        state        <= SETUP;
                        lat_we       <= bus.cpu_we;
                        lat_io       <= bus.cpu_io;
                        cnt          <= 5'd0;
                        cap_vld      <= 1'b0;
                        bus.cpu_busy <= 1'b1;
                        bus.A        <= bus.cpu_io ? {12'h000, bus.cpu_addr[7:0]} : bus.cpu_addr;
                        bus.DIN      <= bus.cpu_wdata;
                        bus.BYTE_SEL <= bus.cpu_be;
                        bus.CHARA    <= !bus.cpu_io && (bus.cpu_addr[19:16] == 4'hD);
                        bus.CHARA_P  <= !bus.cpu_io && (bus.cpu_addr[19:14] == 6'b110010);
                    end
                end
                SETUP: begin
                    state    <= STROBE;
                    bus.MRD  <= !lat_we && !lat_io;
                    bus.MWR  <=  lat_we && !lat_io;
                    bus.IORD <= !lat_we &&  lat_io;
                    bus.IOWR <=  lat_we &&  lat_io;
                end
                STROBE: begin
                    cnt <= (cnt == 5'h1F) ? cnt : cnt_inc[4:0];
                    if (!lat_we && bus.BUS_DIN_VALID) begin
                        cap_dat <= bus.BUS_DIN;
                        cap_vld <= 1'b1;
                    end
                    if (strobe_done) begin
                        state         <= HOLD;
                        bus.MRD       <= 1'b0;
                        bus.MWR       <= 1'b0;
                        bus.IORD      <= 1'b0;
                        bus.IOWR      <= 1'b0;
                        bus.cpu_ready <= 1'b1;
                        // data arriving in the final strobe cycle overrides any earlier capture
                        if (!lat_we) begin
                            bus.cpu_rdata <= bus.BUS_DIN_VALID ? bus.BUS_DIN :
                                             cap_vld           ? cap_dat     : 16'hFFFF;
                        end
                    end
                end
                HOLD: begin
                    state        <= IDLE;
                    bus.cpu_busy <= 1'b0;
                    bus.A        <= 20'h00000;
                    bus.DIN      <= 16'h0000;
                    bus.BYTE_SEL <= 2'b00;
                    bus.CHARA    <= 1'b0;
                    bus.CHARA_P  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_board_b_bus_initiator.sv
// Directed bench for board_b_bus_initiator: per-transaction expectations go to a scoreboard
// queue when the request is driven and are popped when cpu_ready appears.
module tb_board_b_bus_initiator;
    logic clk;
    logic reset;

    board_b_bus_initiator_if bif ();

    board_b_bus_initiator #(
        .STROBE_CYCLES(2),
        .MAX_WAIT     (6)
    ) dut (
        .CLK_32M(clk),
        .reset  (reset),
        .bus    (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rdata;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"},    32'(bif.cpu_busy), 32'd0);
        check({tag, " A"},       32'(bif.A), 32'd0);
        check({tag, " strobes"}, 32'({bif.IOWR, bif.IORD, bif.MWR, bif.MRD}), 32'd0);
        check({tag, " chara"},   32'({bif.CHARA, bif.CHARA_P}), 32'd0);
    endtask

    // exp_stb is one-hot {IOWR, IORD, MWR, MRD}; strobe cycle j sees BUS_DIN = vdat + j when vmask[j]
    task automatic run_txn(input string name, input logic we, input logic io,
                           input logic [19:0] addr, input logic [1:0] be, input logic [15:0] wdata,
                           input logic [15:0] vmask, input logic [15:0] vdat, input int pulse_c,
                           input logic [3:0] exp_stb, input logic [19:0] exp_a,
                           input logic exp_chara, input logic exp_charap,
                           input int exp_len, input logic [15:0] exp_rdata);
        int   c;
        int   nstb;
        bit   bad;
        bit   done;
        exp_t e;
        logic [3:0] s;
        e.rdata = exp_rdata;
        e.lat   = exp_len + 2;
        sb.push_back(e);
        bif.cpu_we    = we;
        bif.cpu_io    = io;
        bif.cpu_addr  = addr;
        bif.cpu_be    = be;
        bif.cpu_wdata = wdata;
        bif.cpu_req   = 1'b1;
        @(posedge clk);
        c = 0; nstb = 0; bad = 0; done = 0;
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
            bif.cpu_req = (c == pulse_c);
            s = {bif.IOWR, bif.IORD, bif.MWR, bif.MRD};
            if (c == 1) begin
                check({name, " setup busy"},    32'(bif.cpu_busy), 32'd1);
                check({name, " setup strobes"}, 32'(s), 32'd0);
                check({name, " A"},             32'(bif.A), 32'(exp_a));
                check({name, " CHARA"},         32'(bif.CHARA), 32'(exp_chara));
                check({name, " CHARA_P"},       32'(bif.CHARA_P), 32'(exp_charap));
                check({name, " BYTE_SEL"},      32'(bif.BYTE_SEL), 32'(be));
                check({name, " DIN"},           32'(bif.DIN), 32'(wdata));
            end else if (s == exp_stb) begin
                nstb++;
            end else if (s != 4'b0000) begin
                bad = 1;
            end
            if (bif.cpu_ready) begin
                done = 1;
                e = sb.pop_front();
                check({name, " latency"}, 32'(c), 32'(e.lat));
                check({name, " rdata"},   32'(bif.cpu_rdata), 32'(e.rdata));
                check({name, " hold A"},  32'(bif.A), 32'(exp_a));
            end
            bif.BUS_DIN_VALID = (c <= 16) ? vmask[c-1] : 1'b0;
            bif.BUS_DIN       = vdat + 16'(c - 1);
        end
        if (!done) sb.delete();
        check({name, " completed"},     32'(done), 32'd1);
        check({name, " strobe length"}, 32'(nstb), 32'(exp_len));
        check({name, " stray strobe"},  32'(bad), 32'd0);
        @(negedge clk);
        bif.BUS_DIN_VALID = 1'b0;
        bif.cpu_req       = 1'b0;
        check_idle({name, " idle"});
        check({name, " ready low"}, 32'(bif.cpu_ready), 32'd0);
    endtask

    initial begin
        bit seen;
        bif.cpu_req       = 1'b0;
        bif.cpu_we        = 1'b0;
        bif.cpu_io        = 1'b0;
        bif.cpu_addr      = 20'h0;
        bif.cpu_be        = 2'b00;
        bif.cpu_wdata     = 16'h0;
        bif.BUS_DIN       = 16'h0;
        bif.BUS_DIN_VALID = 1'b0;
        reset             = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset ready",    32'(bif.cpu_ready), 32'd0);
        check("reset overrun",  32'(bif.cpu_overrun), 32'd0);
        check("reset rdata",    32'(bif.cpu_rdata), 32'hFFFF);
        check("reset DIN",      32'(bif.DIN), 32'd0);
        check("reset BYTE_SEL", 32'(bif.BYTE_SEL), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_txn("mem write", 1, 0, 20'hD8004, 2'b11, 16'h1234, 16'h0000, 16'h0, 0,
                4'b0010, 20'hD8004, 1, 0, 2, 16'hFFFF);
        run_txn("io write", 1, 1, 20'hD0082, 2'b01, 16'h00AB, 16'h0000, 16'h0, 0,
                4'b1000, 20'h00082, 0, 0, 2, 16'hFFFF);
        run_txn("palette read", 0, 0, 20'hC8010, 2'b11, 16'h0000, 16'h0010, 16'h7C1B, 0,
                4'b0001, 20'hC8010, 0, 1, 4, 16'h7C1F);
        check("overrun before", 32'(bif.cpu_overrun), 32'd0);
        run_txn("write with overrun pulse", 1, 0, 20'h01234, 2'b10, 16'h5555, 16'h0000, 16'h0, 3,
                4'b0010, 20'h01234, 0, 0, 2, 16'h7C1F);
        check("overrun after", 32'(bif.cpu_overrun), 32'd1);
        run_txn("read timeout", 0, 0, 20'hD1234, 2'b11, 16'h0000, 16'h0000, 16'h0, 0,
                4'b0001, 20'hD1234, 1, 0, 8, 16'hFFFF);
        run_txn("io read last wins", 0, 1, 20'hAB345, 2'b01, 16'h0000, 16'h0006, 16'h0A00, 0,
                4'b0100, 20'h00045, 0, 0, 2, 16'h0A02);
        run_txn("read valid outside strobe", 0, 0, 20'hCC000, 2'b11, 16'h0000, 16'h0201, 16'h1111, 0,
                4'b0001, 20'hCC000, 0, 0, 8, 16'hFFFF);
        run_txn("read valid last cycle", 0, 0, 20'h12345, 2'b11, 16'h0000, 16'h0100, 16'h2000, 0,
                4'b0001, 20'h12345, 0, 0, 8, 16'h2008);
        check("overrun sticky", 32'(bif.cpu_overrun), 32'd1);

        bif.cpu_we   = 1'b0;
        bif.cpu_io   = 1'b0;
        bif.cpu_addr = 20'h00100;
        bif.cpu_be   = 2'b11;
        bif.cpu_req  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bif.cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        check("mid-strobe MRD", 32'(bif.MRD), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("post-reset MRD",     32'(bif.MRD), 32'd0);
        check("post-reset busy",    32'(bif.cpu_busy), 32'd0);
        check("post-reset ready",   32'(bif.cpu_ready), 32'd0);
        check("post-reset overrun", 32'(bif.cpu_overrun), 32'd0);
        check("post-reset rdata",   32'(bif.cpu_rdata), 32'hFFFF);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bif.cpu_ready || bif.cpu_busy) seen = 1;
        end
        check("no ready after reset", 32'(seen), 32'd0);
        run_txn("read after reset", 0, 0, 20'h00100, 2'b11, 16'h0000, 16'h0004, 16'hBEE0, 0,
                4'b0001, 20'h00100, 0, 0, 2, 16'hBEE2);
        check("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
